// File: rtl/matrixmult_accum_pkg.sv
// Shared widths and FSM state type for the matrix-multiply dot-product accumulator.
package matrixmult_accum_pkg;

    localparam int unsigned PROD_WIDTH_DEF = 29;
    localparam int unsigned ACC_WIDTH_DEF  = 40;
    localparam int unsigned CNT_WIDTH_DEF  = 12;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PARTIAL = 1'b1
    } accum_state_t;

endpackage

// File: rtl/matrixmult_sat_add.sv
// Combinational unsigned saturating adder; b is zero-extended to the sum width.
module matrixmult_sat_add #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned B_WIDTH = WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0] b,
    output logic [WIDTH-1:0]   sum,
    output logic               sat
);

    logic [WIDTH:0] full;

    // One extra bit catches the carry out that triggers saturation.
    assign full = {1'b0, a} + (WIDTH+1)'(b);
    assign sat  = full[WIDTH];
    assign sum  = sat ? '1 : full[WIDTH-1:0];

endmodule

// File: rtl/matrixmult_dot_accum.sv
// Accumulates product beats into dot-product sums and presents each finished sum
// through a one-deep registered output with a valid/ready handshake.
module matrixmult_dot_accum
    import matrixmult_accum_pkg::*;
#(
    parameter int unsigned PROD_WIDTH = PROD_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [PROD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf,
    input  logic                  out_ready
);

    accum_state_t         state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;

    logic [ACC_WIDTH-1:0] base_acc;
    logic [CNT_WIDTH-1:0] base_cnt;
    logic                 base_ovf;
    logic [ACC_WIDTH-1:0] sum_next;
    logic                 sum_sat;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 cnt_sat_unused;
    logic                 ovf_next;
    logic                 accept;
    logic                 consume;

    // Stall only while a result is held and not being taken this cycle.
    assign in_ready = ce & ~(out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = ce & out_valid & out_ready;

    // A new dot product starts from zero regardless of stale register contents.
    always_comb begin
        base_acc = '0;
        base_cnt = '0;
        base_ovf = 1'b0;
        if (state == ST_PARTIAL) begin
            base_acc = acc;
            base_cnt = cnt;
            base_ovf = ovf;
        end
    end

    matrixmult_sat_add #(
        .WIDTH   (ACC_WIDTH),
        .B_WIDTH (PROD_WIDTH)
    ) u_sum_add (
        .a   (base_acc),
        .b   (in_data),
        .sum (sum_next),
        .sat (sum_sat)
    );

    matrixmult_sat_add #(
        .WIDTH   (CNT_WIDTH),
        .B_WIDTH (1)
    ) u_cnt_add (
        .a   (base_cnt),
        .b   (1'b1),
        .sum (cnt_next),
        .sat (cnt_sat_unused)
    );

    assign ovf_next = base_ovf | sum_sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            if (consume) begin
                out_valid <= 1'b0;
            end
            // A same-cycle last beat reloads the output and overrides the clear above.
            if (accept) begin
                if (in_last) begin
                    out_data  <= sum_next;
                    out_count <= cnt_next;
                    out_ovf   <= ovf_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf       <= 1'b0;
                    state     <= ST_EMPTY;
                end else begin
                    acc       <= sum_next;
                    cnt       <= cnt_next;
                    ovf       <= ovf_next;
                    state     <= ST_PARTIAL;
                end
            end
        end
    end

endmodule
